// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: op_sel codes, slice op codes, FSM states.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_NOR = 3'b100;

    localparam logic [1:0] SOP_AND  = 2'b00;
    localparam logic [1:0] SOP_OR   = 2'b01;
    localparam logic [1:0] SOP_ADD  = 2'b10;
    localparam logic [1:0] SOP_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SLT2 = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR);
    endfunction

endpackage

// File: rtl/bit_serial_alu_seq.sv
// Drives an external 1-bit ALU slice LSB first, one bit per cycle; SLT adds a second pass through the less input.
// Optional SERIAL_ALU_OVF_EN adds the ovf port and makes SLT a true signed compare.
module bit_serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
`ifdef SERIAL_ALU_OVF_EN
    output logic             ovf,
`endif
    output logic             slice_in1,
    output logic             slice_in2,
    output logic             slice_cin,
    output logic             slice_ainvert,
    output logic             slice_binvert,
    output logic             slice_less,
    output logic [1:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [2:0]       r_op;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic             r_sign;

    logic             w_active;
    logic             w_drive;
    logic             w_last;
    logic             w_sign;
    logic [WIDTH-1:0] w_sh_next;

    assign w_active = (r_state == ST_RUN) || (r_state == ST_SLT2);
    // Reserved ops keep every data input of the slice at 0 so the pass yields 0.
    assign w_drive  = w_active && op_is_valid(r_op);
    assign w_last   = (r_idx == IDXW'(WIDTH - 1));

`ifdef SERIAL_ALU_OVF_EN
    logic w_ovf;
    assign w_ovf  = r_carry ^ slice_cout;
    assign w_sign = slice_result ^ w_ovf;
`else
    assign w_sign = slice_result;
`endif

    assign slice_in1     = w_drive ? r_a[r_idx] : 1'b0;
    assign slice_in2     = w_drive ? r_b[r_idx] : 1'b0;
    assign slice_cin     = w_drive ? r_carry : 1'b0;
    assign slice_ainvert = w_active && (r_op == OP_NOR);
    assign slice_binvert = w_active && ((r_op == OP_SUB) || (r_op == OP_NOR) ||
                                        ((r_op == OP_SLT) && (r_state == ST_RUN)));
    assign slice_less    = (r_state == ST_SLT2) && (r_idx == '0) && r_sign;

    always_comb begin
        slice_op = SOP_AND;
        if (r_state == ST_SLT2) begin
            slice_op = SOP_LESS;
        end else if (r_state == ST_RUN) begin
            case (r_op)
                OP_OR:                  slice_op = SOP_OR;
                OP_ADD, OP_SUB, OP_SLT: slice_op = SOP_ADD;
                default:                slice_op = SOP_AND;
            endcase
        end
    end

    // Result including the bit being produced this cycle, so y can be registered on the last pass edge.
    always_comb begin
        w_sh_next        = r_sh;
        w_sh_next[r_idx] = slice_result;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sh    <= '0;
            r_op    <= OP_AND;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sign  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            y       <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op_sel;
                        r_idx   <= '0;
                        r_sh    <= '0;
                        r_carry <= (op_sel == OP_SUB) || (op_sel == OP_SLT);
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sh[r_idx] <= slice_result;
                    r_carry     <= slice_cout;
                    r_idx       <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_idx <= '0;
                        if (r_op == OP_SLT) begin
                            r_sign  <= w_sign;
                            r_state <= ST_SLT2;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            y       <= w_sh_next;
                            zero    <= (w_sh_next == '0);
                            cout    <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? slice_cout : 1'b0;
`ifdef SERIAL_ALU_OVF_EN
                            ovf     <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? w_ovf : 1'b0;
`endif
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SLT2: begin
                    r_sh[r_idx] <= slice_result;
                    r_idx       <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_idx   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        y       <= w_sh_next;
                        zero    <= (w_sh_next == '0);
                        cout    <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
                        ovf     <= 1'b0;
`endif
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Directed bench for bit_serial_alu_seq with a behavioural 1-bit slice and an expected-result queue.
module tb_bit_serial_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] op_sel;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] y;
    logic       cout;
    logic       zero;
    logic       ovf;
    logic       s_in1, s_in2, s_cin, s_ainv, s_binv, s_less;
    logic [1:0] s_op;
    logic       s_result, s_cout;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct packed {
        logic [7:0] y;
        logic       cout;
        logic       zero;
        logic       ovf;
        logic [7:0] lat;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    bit_serial_alu_seq #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op_sel       (op_sel),
        .a            (a_in),
        .b            (b_in),
        .busy         (busy),
        .done         (done),
        .y            (y),
        .cout         (cout),
        .zero         (zero),
`ifdef SERIAL_ALU_OVF_EN
        .ovf          (ovf),
`endif
        .slice_in1    (s_in1),
        .slice_in2    (s_in2),
        .slice_cin    (s_cin),
        .slice_ainvert(s_ainv),
        .slice_binvert(s_binv),
        .slice_less   (s_less),
        .slice_op     (s_op),
        .slice_result (s_result),
        .slice_cout   (s_cout)
    );

`ifndef SERIAL_ALU_OVF_EN
    assign ovf = 1'b0;
`endif

    // Behavioural 1-bit ALU slice (AND / OR / full adder / less pass-through).
    always_comb begin
        logic ea, eb;
        ea       = s_in1 ^ s_ainv;
        eb       = s_in2 ^ s_binv;
        s_cout   = (ea & eb) | (ea & s_cin) | (eb & s_cin);
        s_result = 1'b0;
        case (s_op)
            2'b00:   s_result = ea & eb;
            2'b01:   s_result = ea | eb;
            2'b10:   s_result = ea ^ eb ^ s_cin;
            default: s_result = s_less;
        endcase
    end

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [8:0] s;
        e      = '0;
        e.lat  = 8'd9;
        s      = {1'b0, a} + {1'b0, ~b} + 9'd1;
        case (op)
            3'b000: e.y = a & b;
            3'b001: e.y = a | b;
            3'b100: e.y = ~(a | b);
            3'b010: begin
                s      = {1'b0, a} + {1'b0, b};
                e.y    = s[7:0];
                e.cout = s[8];
                e.ovf  = (a[7] == b[7]) && (s[7] != a[7]);
            end
            3'b110: begin
                e.y    = s[7:0];
                e.cout = s[8];
                e.ovf  = (a[7] != b[7]) && (s[7] != a[7]);
            end
            3'b111: begin
                e.lat = 8'd17;
`ifdef SERIAL_ALU_OVF_EN
                e.y = {7'b0, ($signed(a) < $signed(b))};
`else
                e.y = {7'b0, s[7]};
`endif
            end
            default: e.y = 8'h00;
        endcase
        e.zero = (e.y == 8'h00);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // mode 0: plain; 1: second start while busy; 2: start held in the done cycle
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int mode);
        int   cnt;
        logic got;
        int   extra;
        exp_t e;
        q.push_back(model(op, a, b));
        op_sel = op; a_in = a; b_in = b; start = 1'b1;
        cnt = 0; got = 1'b0;
        while (cnt < 40 && !got) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) start = 1'b0;
            if (mode == 1 && cnt == 3) begin
                start = 1'b1; a_in = ~a; b_in = b ^ 8'h5A; op_sel = 3'b001;
            end
            if (mode == 1 && cnt == 4) start = 1'b0;
            if (done === 1'b1) got = 1'b1;
        end
        check({tag, ":done_seen"}, 32'(got), 32'd1);
        e = q.pop_front();
        if (got) begin
            check({tag, ":y"}, 32'(y), 32'(e.y));
            check({tag, ":cout"}, 32'(cout), 32'(e.cout));
            check({tag, ":zero"}, 32'(zero), 32'(e.zero));
            check({tag, ":latency"}, 32'(cnt), 32'(e.lat));
            check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
            check({tag, ":slice_idle"}, 32'({s_in1, s_in2, s_cin, s_ainv, s_binv, s_less, s_op}), 32'd0);
`ifdef SERIAL_ALU_OVF_EN
            check({tag, ":ovf"}, 32'(ovf), 32'(e.ovf));
`endif
            if (mode == 2) begin
                op_sel = 3'b010; a_in = 8'h11; b_in = 8'h22; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            check({tag, ":done_pulse"}, 32'(done), 32'd0);
            if (mode != 0) begin
                extra = 0;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (done === 1'b1 || busy === 1'b1) extra++;
                end
                check({tag, ":no_extra_op"}, 32'(extra), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_sel = 3'b000; a_in = 8'h00; b_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:y", 32'(y), 32'd0);
        check("reset:cout_zero", 32'({cout, zero}), 32'd0);
        check("reset:slice", 32'({s_in1, s_in2, s_cin, s_ainv, s_binv, s_less, s_op}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_7f_01", 3'b010, 8'h7F, 8'h01, 0);
        run_op("sub_05_05", 3'b110, 8'h05, 8'h05, 0);
        run_op("slt_80_01", 3'b111, 8'h80, 8'h01, 0);
        run_op("slt_01_80", 3'b111, 8'h01, 8'h80, 0);
        run_op("nor_f0_0c", 3'b100, 8'hF0, 8'h0C, 0);
        run_op("or_f0_0c",  3'b001, 8'hF0, 8'h0C, 0);
        run_op("rsv_011",   3'b011, 8'hFF, 8'hFF, 0);
        run_op("and_f0_3c", 3'b000, 8'hF0, 8'h3C, 0);
        run_op("add_ff_01", 3'b010, 8'hFF, 8'h01, 0);
        run_op("sub_03_05", 3'b110, 8'h03, 8'h05, 0);
        run_op("slt_fe_02", 3'b111, 8'hFE, 8'h02, 0);
        run_op("busy_start", 3'b010, 8'h12, 8'h34, 1);
        run_op("done_start", 3'b001, 8'hA0, 8'h05, 2);

        // Reset while RUN is at bit 4; y still holds the previous nonzero result.
        op_sel = 3'b010; a_in = 8'h3C; b_in = 8'h41; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst:busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst:busy", 32'(busy), 32'd0);
        check("midrst:y", 32'(y), 32'd0);
        check("midrst:done", 32'(done), 32'd0);
        check("midrst:slice", 32'({s_in1, s_in2, s_cin, s_ainv, s_binv, s_less, s_op}), 32'd0);
        run_op("after_rst", 3'b010, 8'h3C, 8'h41, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
